mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one dual-port feature/weight memory between two read requesters and two write requesters.
//  Memory port A is read-only; port B is write-only; the memory has chip-select and 1-cycle read latency.
//  Read requesters are the PE array fetch and the output/debug dump; write requesters are the DMA loader and the PE result writeback.
//  Per-port round-robin arbitration, a same-address RAW guard, and memory control generation (csen/rdena/wrenb).
// PARAMETERS
//  ADDR_WIDTH  13  memory address width
//  DATA_WIDTH  8   memory data width
// PORTS
//  clk           in   1            single clock; all state on rising edge
//  rst_n         in   1            asynchronous active-low reset
//  enable        in   1            global enable; 0 = issue no new grants
//  rd_req        in   2            read request per requester [k]
//  rd_addr       in   2*ADDR_WIDTH read address; slice k = [k*AW +: AW]
//  rd_gnt        out  2            read grant, one-hot or zero, combinational
//  rd_vld        out  2            read data valid for requester k, registered
//  rd_data       out  DATA_WIDTH   read data = mem_data_a; meaningful only while rd_vld != 0
//  wr_req        in   2            write request per requester
//  wr_addr       in   2*ADDR_WIDTH write address slices
//  wr_data       in   2*DATA_WIDTH write data slices
//  wr_gnt        out  2            write grant, one-hot or zero, combinational
//  mem_csen      out  1            memory chip select
//  mem_rdena     out  1            memory port-A read enable
//  mem_addr_a    out  ADDR_WIDTH   memory read address
//  mem_data_a    in   DATA_WIDTH   memory read data; memory drives 0 when not reading
//  mem_wrenb     out  1            memory port-B write enable
//  mem_addr_b    out  ADDR_WIDTH   memory write address
//  mem_data_b    out  DATA_WIDTH   memory write data
// BEHAVIOUR
//  Handshake
//  - Requester holds req, addr and data stable until it sees gnt=1 in a cycle.
//  - The transfer completes at the end of that cycle; req may drop or change from the next cycle.
//  Write arbitration
//  - Register wr_last (1b) holds the last granted writer.
//  - If both writers request, grant ~wr_last; otherwise grant the sole requester.
//  - wr_last updates on every write grant.
//  Read arbitration
//  - Same scheme, with register rd_last.
//  RAW guard
//  - If the granted write address equals the read candidate's address in the same cycle, the read grant is withheld.
//  - rd_last is not updated; the requester retries next cycle and then reads the new data.
//  - Reads never return pre-write data for a same-cycle collision.
//  Memory outputs (combinational from grants)
//  - mem_wrenb  = |wr_gnt
//  - mem_rdena  = |rd_gnt
//  - mem_csen   = mem_wrenb | mem_rdena
//  - addr/data mux = granted slice; 0 when no grant.
//  Read latency
//  - rd_vld <= rd_gnt (registered): valid exactly 1 cycle after grant, one-hot.
//  - rd_data is not registered by this block.
//  enable=0
//  - All gnt=0 and all mem enables=0; pointers hold.
//  - A read granted in the previous cycle still asserts rd_vld.
//  Reset (rst_n=0, asynchronous)
//  - rd_last=wr_last=1, so requester 0 is favoured first; rd_vld=0.
//  - All grants and mem_* outputs forced 0 while reset is asserted.
//  - Reset mid-read drops the pending rd_vld; the requester must reissue.
//  Read and write to different addresses in the same cycle are both granted (full dual-port concurrency).
// TESTING
//  1. Reset, then rd_req=01 with addr 0x005 after the memory is preloaded with 0xA5 at 0x005
//     -> rd_gnt=01 in cycle t; rd_vld=01, rd_data=0xA5 at t+1; mem_csen=1 only at t.
//  2. Both writers request continuously for 4 cycles
//     -> wr_gnt sequence 01,10,01,10; mem_wrenb=1 each cycle.
//  3. wr_req=01 (addr 0x010, data 0x3C) and rd_req=01 (addr 0x010) in the same cycle
//     -> write granted, rd_gnt=00; next cycle rd_gnt=01; the cycle after, rd_data=0x3C.
//  4. Read 0x020 and write 0x021 in the same cycle
//     -> both granted; mem_csen=1, mem_rdena=1, mem_wrenb=1.
//  5. Requests pending and enable=0 for 3 cycles
//     -> no grants, mem_csen=0; after enable=1 the favoured requester is unchanged.
//  6. rst_n asserted in the cycle after a read grant
//     -> rd_vld=0 immediately; all mem_* outputs 0; after release, requester 0 wins the first tie.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : requester-side and memory-side bus of the port arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic                    i_enable;
  logic [1:0]              i_rd_req;
  logic [2*ADDR_WIDTH-1:0] i_rd_addr;
  logic [1:0]              o_rd_gnt;
  logic [1:0]              o_rd_vld;
  logic [DATA_WIDTH-1:0]   o_rd_data;
  logic [1:0]              i_wr_req;
  logic [2*ADDR_WIDTH-1:0] i_wr_addr;
  logic [2*DATA_WIDTH-1:0] i_wr_data;
  logic [1:0]              o_wr_gnt;
  logic                    o_mem_csen;
  logic                    o_mem_rdena;
  logic [ADDR_WIDTH-1:0]   o_mem_addr_a;
  logic [DATA_WIDTH-1:0]   i_mem_data_a;
  logic                    o_mem_wrenb;
  logic [ADDR_WIDTH-1:0]   o_mem_addr_b;
  logic [DATA_WIDTH-1:0]   o_mem_data_b;

  modport slave (
    input  i_enable, i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data, i_mem_data_a,
    output o_rd_gnt, o_rd_vld, o_rd_data, o_wr_gnt, o_mem_csen, o_mem_rdena,
           o_mem_addr_a, o_mem_wrenb, o_mem_addr_b, o_mem_data_b
  );

  modport master (
    output i_enable, i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data, i_mem_data_a,
    input  o_rd_gnt, o_rd_vld, o_rd_data, o_wr_gnt, o_mem_csen, o_mem_rdena,
           o_mem_addr_a, o_mem_wrenb, o_mem_addr_b, o_mem_data_b
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : round-robin sharing of a read port and a write port
//                    between two requesters each, with same-address RAW guard
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  mem_port_arbiter_if.slave     bus
);

  logic                  r_rd_last;
  logic                  r_wr_last;
  logic [1:0]            r_rd_vld;

  logic                  w_active;
  logic                  w_rd_idx;
  logic                  w_wr_idx;
  logic [ADDR_WIDTH-1:0] w_rd_addr_sel;
  logic [ADDR_WIDTH-1:0] w_wr_addr_sel;
  logic [DATA_WIDTH-1:0] w_wr_data_sel;
  logic                  w_wr_any;
  logic                  w_rd_any;
  logic                  w_raw;
  logic [1:0]            w_rd_gnt;
  logic [1:0]            w_wr_gnt;

  // Grants are gated by reset as well so nothing reaches the memory while rst_n is low.
  always_comb begin
    w_active      = bus.i_enable & rst_n;
    w_rd_idx      = (&bus.i_rd_req) ? ~r_rd_last : bus.i_rd_req[1];
    w_wr_idx      = (&bus.i_wr_req) ? ~r_wr_last : bus.i_wr_req[1];
    w_rd_addr_sel = w_rd_idx ? bus.i_rd_addr[ADDR_WIDTH +: ADDR_WIDTH]
                             : bus.i_rd_addr[0 +: ADDR_WIDTH];
    w_wr_addr_sel = w_wr_idx ? bus.i_wr_addr[ADDR_WIDTH +: ADDR_WIDTH]
                             : bus.i_wr_addr[0 +: ADDR_WIDTH];
    w_wr_data_sel = w_wr_idx ? bus.i_wr_data[DATA_WIDTH +: DATA_WIDTH]
                             : bus.i_wr_data[0 +: DATA_WIDTH];
    w_wr_any      = w_active & (|bus.i_wr_req);
    // A read colliding with this cycle's write waits one cycle and then sees the new data.
    w_raw         = w_wr_any & (w_wr_addr_sel == w_rd_addr_sel);
    w_rd_any      = w_active & (|bus.i_rd_req) & ~w_raw;
    w_rd_gnt      = 2'b00;
    w_wr_gnt      = 2'b00;
    if (w_rd_any) begin
      w_rd_gnt = w_rd_idx ? 2'b10 : 2'b01;
    end
    if (w_wr_any) begin
      w_wr_gnt = w_wr_idx ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_last <= 1'b1;
      r_wr_last <= 1'b1;
      r_rd_vld  <= 2'b00;
    end else begin
      if (w_rd_any) begin
        r_rd_last <= w_rd_idx;
      end
      if (w_wr_any) begin
        r_wr_last <= w_wr_idx;
      end
      r_rd_vld <= w_rd_gnt;
    end
  end

  assign bus.o_rd_gnt     = w_rd_gnt;
  assign bus.o_wr_gnt     = w_wr_gnt;
  assign bus.o_rd_vld     = r_rd_vld;
  assign bus.o_rd_data    = bus.i_mem_data_a;
  assign bus.o_mem_rdena  = w_rd_any;
  assign bus.o_mem_wrenb  = w_wr_any;
  assign bus.o_mem_csen   = w_rd_any | w_wr_any;
  assign bus.o_mem_addr_a = w_rd_any ? w_rd_addr_sel : '0;
  assign bus.o_mem_addr_b = w_wr_any ? w_wr_addr_sel : '0;
  assign bus.o_mem_data_b = w_wr_any ? w_wr_data_sel : '0;

endmodule

`default_nettype wire
